// File: rtl/barrett_pkg.sv
// Shared sizing, step counts and FSM encoding for the serial Barrett reducer.
package barrett_pkg;
  localparam int DATA_LENGTH  = 64;
  localparam int BLOCK_LENGTH = 16;
  localparam int NUM_BLOCKS   = DATA_LENGTH / BLOCK_LENGTH;
  localparam int MUL_Q_STEPS  = 4 * NUM_BLOCKS * NUM_BLOCKS;
  localparam int MUL_M_STEPS  = NUM_BLOCKS * (NUM_BLOCKS + 1);
  localparam int CNT_W        = $clog2(2 * NUM_BLOCKS);

  typedef logic [CNT_W-1:0] digit_cnt_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL_Q = 3'd2,
    MUL_M = 3'd3,
    SUB   = 3'd4,
    CORR  = 3'd5,
    DONE  = 3'd6
  } state_t;
endpackage

// File: rtl/barrett_block_mul.sv
// Registered BLOCK_LENGTH x BLOCK_LENGTH unsigned multiplier, one cycle latency.
module barrett_block_mul
  import barrett_pkg::*;
(
  input  logic                      clk_i,
  input  logic [BLOCK_LENGTH-1:0]   a_i,
  input  logic [BLOCK_LENGTH-1:0]   b_i,
  output logic [2*BLOCK_LENGTH-1:0] p_o
);
  always_ff @(posedge clk_i)
    p_o <= {{BLOCK_LENGTH{1'b0}}, a_i} * {{BLOCK_LENGTH{1'b0}}, b_i};
endmodule

// File: rtl/barrett_reduce_serial.sv
// Digit-serial Barrett reduction x mod m through one shared block multiplier.
// Optional BARRETT_ERR_EN adds err_o flagging precondition violations.
module barrett_reduce_serial
  import barrett_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       finish_o,
  input  logic [2*DATA_LENGTH-1:0]   indata_x_i,
  input  logic [DATA_LENGTH-1:0]     modulus_i,
  input  logic [2*DATA_LENGTH-1:0]   mu_i,
  output logic [DATA_LENGTH-1:0]     outdata_r_o
`ifdef BARRETT_ERR_EN
  , output logic                     err_o
`endif
);
  localparam int K = DATA_LENGTH;
  localparam int B = BLOCK_LENGTH;
  localparam int N = NUM_BLOCKS;

  state_t           state;
  logic [2*K-1:0]   x_r, mu_r;
  logic [K-1:0]     m_r;
  logic [K:0]       q_r;
  logic [4*K-1:0]   acc, acc_add, acc_next;
  logic [K+1:0]     r_r, r_new, r_sub, m_ext;
  digit_cnt_t       a_idx, b_idx, a_last, b_last;
  logic             issue_done, issue, p_vld, corr_cnt;
  logic [CNT_W:0]   p_shift;
  logic [B-1:0]     op_a, op_b;
  logic [2*B-1:0]   prod;
  logic [(N+1)*B-1:0] q_ext;

  assign busy_o   = (state != IDLE) && (state != DONE);
  assign finish_o = (state == DONE);
  assign q_ext    = {{((N+1)*B-K-1){1'b0}}, q_r};
  assign m_ext    = {2'b00, m_r};
  assign issue    = ((state == MUL_Q) || (state == MUL_M)) && !issue_done;

  // MUL_Q walks 2N x 2N digits of x and mu; MUL_M walks N+1 digits of q_hat by N of m.
  always_comb begin
    op_a   = x_r[a_idx*B +: B];
    op_b   = mu_r[b_idx*B +: B];
    a_last = digit_cnt_t'(2*N-1);
    b_last = digit_cnt_t'(2*N-1);
    if (state == MUL_M) begin
      op_a   = q_ext[a_idx*B +: B];
      op_b   = m_r[b_idx*B +: B];
      a_last = digit_cnt_t'(N);
      b_last = digit_cnt_t'(N-1);
    end
  end

  barrett_block_mul u_mul (
    .clk_i (clk_i),
    .a_i   (op_a),
    .b_i   (op_b),
    .p_o   (prod)
  );

  assign acc_add  = {{(4*K-2*B){1'b0}}, prod} << (p_shift * B);
  assign acc_next = p_vld ? acc + acc_add : acc;
  // Only the low K+2 bits of x - T are meaningful since the true remainder is < 3m.
  assign r_new    = x_r[K+1:0] - acc[K+1:0];
  assign r_sub    = r_r - m_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      x_r         <= '0;
      mu_r        <= '0;
      m_r         <= '0;
      q_r         <= '0;
      acc         <= '0;
      r_r         <= '0;
      a_idx       <= '0;
      b_idx       <= '0;
      issue_done  <= 1'b0;
      p_vld       <= 1'b0;
      p_shift     <= '0;
      corr_cnt    <= 1'b0;
      outdata_r_o <= '0;
`ifdef BARRETT_ERR_EN
      err_o       <= 1'b0;
`endif
    end else begin
      p_vld   <= issue;
      p_shift <= {1'b0, a_idx} + {1'b0, b_idx};
      case (state)
        IDLE: if (start_i) state <= LOAD;
        LOAD: begin
          x_r        <= indata_x_i;
          m_r        <= modulus_i;
          mu_r       <= mu_i;
          acc        <= '0;
          a_idx      <= '0;
          b_idx      <= '0;
          issue_done <= 1'b0;
          corr_cnt   <= 1'b0;
`ifdef BARRETT_ERR_EN
          err_o      <= (modulus_i < K'(2));
`endif
          state      <= MUL_Q;
        end
        MUL_Q, MUL_M: begin
          acc <= acc_next;
          if (issue) begin
            if (b_idx == b_last) begin
              b_idx <= '0;
              if (a_idx == a_last) issue_done <= 1'b1;
              else                 a_idx <= a_idx + 1'b1;
            end else begin
              b_idx <= b_idx + 1'b1;
            end
          end else begin
            // drain cycle: last product lands in acc_next
            issue_done <= 1'b0;
            a_idx      <= '0;
            b_idx      <= '0;
            if (state == MUL_Q) begin
              q_r   <= acc_next[2*K +: K+1];
              acc   <= '0;
              state <= MUL_M;
            end else begin
              state <= SUB;
            end
          end
        end
        SUB: begin
          r_r <= r_new;
          if (r_new >= m_ext) state <= CORR;
          else begin
            outdata_r_o <= r_new[K-1:0];
            state       <= DONE;
          end
        end
        CORR: begin
          r_r      <= r_sub;
          corr_cnt <= 1'b1;
          if ((r_sub < m_ext) || corr_cnt) begin
            outdata_r_o <= r_sub[K-1:0];
            state       <= DONE;
`ifdef BARRETT_ERR_EN
            if (r_sub >= m_ext) err_o <= 1'b1;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
